// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / fetch-control stage.
//   fetch_state_t    : FSM encoding (FETCH = normal fetch, SQUASH = drop in-flight access)
//   PC_INCR          : sequential PC increment
//   DEFAULT_RESET_PC : default reset vector
package pc_fetch_unit_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    SQUASH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_mux2.sv
// Generic 32-bit 2:1 multiplexer used for next-PC selection.
//   d0  : selected when sel = 0
//   d1  : selected when sel = 1
//   sel : select
//   y   : output
module mux2_1_32bit (
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic        sel,
  output logic [31:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch control.
// Holds the PC, drives the instruction-memory request, delivers fetched
// PCs to IF/ID and squashes the in-flight access when a redirect arrives
// before the memory has answered.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : decode cannot accept an instruction this cycle
//   branch_taken/target : branch redirect
//   jump/jump_target    : jump redirect (wins over branch)
//   imem_ready          : memory completes the access this cycle
//   imem_req, imem_addr : fetch request and address (address = pc)
//   pc                  : current PC register
//   fetch_valid         : one-cycle pulse, fetch_pc/fetch_pc_plus4 are valid
//   fetch_pc(_plus4)    : PC of delivered instruction and that PC + 4
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_pc_plus4
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic        fetch_valid_nxt;
  logic [31:0] fetch_pc_nxt;
  logic [31:0] fetch_pc_plus4_nxt;

  logic [31:0] seq_pc;
  logic [31:0] br_sel;
  logic [31:0] redir_raw;
  logic [31:0] target;
  logic [31:0] squash_pc;
  logic        redirect;
  logic        complete;

  assign seq_pc    = pc + PC_INCR;
  assign redirect  = jump | branch_taken;
  assign complete  = imem_req & imem_ready;
  assign imem_addr = pc;

  // Next-PC selection: sequential / branch, then that / jump (jump wins).
  mux2_1_32bit u_mux_branch (
    .d0  (seq_pc),
    .d1  (branch_target),
    .sel (branch_taken),
    .y   (br_sel)
  );

  mux2_1_32bit u_mux_jump (
    .d0  (br_sel),
    .d1  (jump_target),
    .sel (jump),
    .y   (redir_raw)
  );

  // Instruction addresses are word aligned; drop any stray low bits.
  assign target = redir_raw & ~32'h3;

  // Leaving SQUASH: a redirect arriving in the completing cycle beats
  // the stored pending target.
  mux2_1_32bit u_mux_pend (
    .d0  (pend_target),
    .d1  (target),
    .sel (redirect),
    .y   (squash_pc)
  );

  always_comb begin
    state_nxt          = state;
    pc_nxt             = pc;
    pend_target_nxt    = pend_target;
    fetch_valid_nxt    = 1'b0;
    fetch_pc_nxt       = fetch_pc;
    fetch_pc_plus4_nxt = fetch_pc_plus4;
    case (state)
      FETCH: begin
        if (redirect && complete) begin
          pc_nxt = target;
        end else if (redirect) begin
          // Access still outstanding: let it finish, discard its data.
          pend_target_nxt = target;
          state_nxt       = SQUASH;
        end else if (complete && !stall) begin
          pc_nxt             = seq_pc;
          fetch_valid_nxt    = 1'b1;
          fetch_pc_nxt       = pc;
          fetch_pc_plus4_nxt = seq_pc;
        end
        // complete && stall: pc holds, same address re-fetched next cycle.
      end
      SQUASH: begin
        if (redirect) begin
          pend_target_nxt = target;
        end
        if (complete) begin
          pc_nxt    = squash_pc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Stage boundary: PC, fetch control and IF/ID handoff registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      imem_req       <= 1'b0;
      pend_target    <= 32'h0;
      fetch_valid    <= 1'b0;
      fetch_pc       <= 32'h0;
      fetch_pc_plus4 <= 32'h0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      imem_req       <= 1'b1;
      pend_target    <= pend_target_nxt;
      fetch_valid    <= fetch_valid_nxt;
      fetch_pc       <= fetch_pc_nxt;
      fetch_pc_plus4 <= fetch_pc_plus4_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;

  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, pc, fetch_pc, fetch_pc_plus4;
  logic        imem_req2, fetch_valid2;
  logic [31:0] imem_addr2, pc2, fetch_pc2, fetch_pc_plus42;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_pc_plus4 (fetch_pc_plus4)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .pc             (pc2),
    .fetch_valid    (fetch_valid2),
    .fetch_pc       (fetch_pc2),
    .fetch_pc_plus4 (fetch_pc_plus42)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [31:0] e_fpc4;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                   input logic jmp, input logic [31:0] jt, input logic rdy,
                   input logic e_req, input logic [31:0] e_pc, input logic e_fv,
                   input logic [31:0] e_fpc, input logic [31:0] e_fpc4);
    vec_t t;
    t.rst = rst; t.stall = st; t.br = br; t.bt = bt; t.jmp = jmp; t.jt = jt; t.rdy = rdy;
    t.e_req = e_req; t.e_pc = e_pc; t.e_fv = e_fv; t.e_fpc = e_fpc; t.e_fpc4 = e_fpc4;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt, input logic rdy);
    stall = st; branch_taken = br; branch_target = bt;
    jump = jmp; jump_target = jt; imem_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);

    //   rst st br bt           jmp jt           rdy  req pc            fv fpc           fpc4
    v(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'h0);
    v(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'h0);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'h0);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h4);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'h8);
    v(0, 1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h8,   0, 32'h4,   32'h8);
    v(0, 1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h8,   0, 32'h4,   32'h8);
    v(0, 1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h8,   0, 32'h4,   32'h8);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hC,   1, 32'h8,   32'hC);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h10,  1, 32'hC,   32'h10);
    v(0, 0, 1, 32'h200, 1, 32'h100, 1, 1, 32'h100, 0, 32'hC,   32'h10);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h104, 1, 32'h100, 32'h104);
    v(0, 0, 1, 32'h41,  0, 32'h0,   0, 1, 32'h104, 0, 32'h100, 32'h104);
    v(0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h104, 0, 32'h100, 32'h104);
    v(0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h104, 0, 32'h100, 32'h104);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h40,  0, 32'h100, 32'h104);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h44,  1, 32'h40,  32'h44);
    v(0, 0, 1, 32'h300, 0, 32'h0,   0, 1, 32'h44,  0, 32'h40,  32'h44);
    v(0, 0, 0, 32'h0,   1, 32'h82,  0, 1, 32'h44,  0, 32'h40,  32'h44);
    v(0, 1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 32'h40,  32'h44);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h84,  1, 32'h80,  32'h84);
    v(0, 0, 1, 32'h500, 0, 32'h0,   0, 1, 32'h84,  0, 32'h80,  32'h84);
    v(0, 0, 0, 32'h0,   1, 32'h600, 1, 1, 32'h600, 0, 32'h80,  32'h84);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h604, 1, 32'h600, 32'h604);
    v(0, 1, 1, 32'h700, 0, 32'h0,   1, 1, 32'h700, 0, 32'h600, 32'h604);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h704, 1, 32'h700, 32'h704);
    v(0, 0, 1, 32'h900, 0, 32'h0,   0, 1, 32'h704, 0, 32'h700, 32'h704);
    v(1, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'h0);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'h0);
    v(0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h4);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].rdy);
      @(posedge clk); #1;
      check("imem_req",       i, {31'h0, imem_req},    {31'h0, vecs[i].e_req});
      check("pc",             i, pc,                   vecs[i].e_pc);
      check("imem_addr",      i, imem_addr,            vecs[i].e_pc);
      check("fetch_valid",    i, {31'h0, fetch_valid}, {31'h0, vecs[i].e_fv});
      check("fetch_pc",       i, fetch_pc,             vecs[i].e_fpc);
      check("fetch_pc_plus4", i, fetch_pc_plus4,       vecs[i].e_fpc4);
    end

    // Reset vector at the top of the address space: PC must wrap to 0.
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    @(posedge clk); #1;
    reset2 = 1'b1;
    @(posedge clk); #1;
    check("wrap_rst_pc",  0, pc2, 32'hFFFF_FFFC);
    check("wrap_rst_req", 0, {31'h0, imem_req2}, 32'h0);
    reset2 = 1'b0;
    @(posedge clk); #1;
    check("wrap_req",  1, {31'h0, imem_req2}, 32'h1);
    check("wrap_pc",   1, pc2, 32'hFFFF_FFFC);
    check("wrap_fv",   1, {31'h0, fetch_valid2}, 32'h0);
    @(posedge clk); #1;
    check("wrap_fv",   2, {31'h0, fetch_valid2}, 32'h1);
    check("wrap_fpc",  2, fetch_pc2, 32'hFFFF_FFFC);
    check("wrap_fpc4", 2, fetch_pc_plus42, 32'h0);
    check("wrap_pc",   2, pc2, 32'h0);
    @(posedge clk); #1;
    check("wrap_fpc",  3, fetch_pc2, 32'h0);
    check("wrap_fpc4", 3, fetch_pc_plus42, 32'h4);

    // Reset while squashing: pending target must be discarded.
    drive(0, 1, 32'h800, 0, 32'h0, 0);
    @(posedge clk); #1;
    check("sq_pc", 0, pc2, 32'h4);
    reset2 = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    @(posedge clk); #1;
    check("sq_rst_pc",  1, pc2, 32'hFFFF_FFFC);
    check("sq_rst_req", 1, {31'h0, imem_req2}, 32'h0);
    reset2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sq_after_pc",  2, pc2, 32'h0);
    check("sq_after_fpc", 2, fetch_pc2, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-control stage of the processor.
- Consumes the next-PC selection built from the existing 32-bit 2:1 muxes (PC+4 / branch / jump) and holds the PC register.
- Drives the instruction-memory request handshake and hands fetched-instruction PCs to the IF/ID boundary.
- Handles stalls, and squashes in-flight fetches on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept a new instruction this cycle
branch_taken  input  1  redirect to branch_target this cycle
branch_target  input  32  branch destination address
jump  input  1  redirect to jump_target this cycle
jump_target  input  32  jump destination address
imem_ready  input  1  instruction memory completes the access this cycle
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; always equals pc
pc  output  32  current PC register
fetch_valid  output  1  registered one-cycle pulse: fetch_pc is a valid fetched instruction address
fetch_pc  output  32  PC of the instruction delivered to IF/ID
fetch_pc_plus4  output  32  fetch_pc + 4, for link/branch computation downstream

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: pc=RESET_PC, imem_req=0, fetch_valid=0, fetch_pc=0, fetch_pc_plus4=0, state=FETCH, pend_target=0.
- imem_req is registered. It is 0 in the cycle after reset deasserts is sampled... precisely: it is 0 while reset is high, and 1 from the first edge after reset is low. It stays 1 thereafter.
- imem_addr = pc (combinational from the register).
- Access completes when imem_req && imem_ready.
- redirect = jump | branch_taken.
- Redirect target: jump_target if jump, else branch_target (jump has priority). Target bits [1:0] are forced to 00.
- seq_pc = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- States: FETCH, SQUASH.
- FETCH state, evaluated in priority order:
  1. redirect && complete: pc <= target; fetch_valid <= 0; stay in FETCH.
  2. redirect && !complete: pend_target <= target; fetch_valid <= 0; go to SQUASH; pc holds. The in-flight access is allowed to finish, and its result is discarded.
  3. complete && !stall: pc <= seq_pc; fetch_valid <= 1; fetch_pc <= pc; fetch_pc_plus4 <= seq_pc.
  4. complete && stall: pc holds; fetch_valid <= 0. The same address is re-requested next cycle (fetch is idempotent).
  5. !complete: pc holds; fetch_valid <= 0.
- SQUASH state:
  - fetch_valid is always 0.
  - A new redirect overwrites pend_target (jump priority applies).
  - On complete: pc <= (redirect this cycle ? new target : pend_target); go to FETCH.
  - stall is ignored in SQUASH.
- Redirect always has priority over stall.
- fetch_pc and fetch_pc_plus4 hold their values when fetch_valid=0.
- Latency: from the completion edge, fetch_valid appears 1 cycle later. The next request address appears the same cycle as fetch_valid.
- Reset mid-access, or in SQUASH: the FSM returns to FETCH; pend_target is discarded; the outstanding memory response is ignored because imem_req=0 during reset.

Decomposition:
- Shared package/header holds:
  - state encoding: FETCH=1'b0, SQUASH=1'b1
  - PC_INCR=32'd4
  - the default reset vector constant
- Next-PC selection reuses two instances of mux2_1_32bit:
  - seq vs branch_target, selected by branch_taken
  - that result vs jump_target, selected by jump
- The pending-target path adds a third mux2_1_32bit. No new sub-module is needed.

Test Plan:
- Reset then imem_ready=1 constant, no stall/redirect:
  - imem_req rises 1 cycle after reset release.
  - fetch_pc sequence is 0, 4, 8, 12, with fetch_valid=1 every cycle.
- stall=1 for 3 cycles at pc=8 with imem_ready=1:
  - imem_addr stays 8 and fetch_valid=0 for 3 cycles.
  - After stall drops: fetch_pc=8, then 12.
- jump=1 (target 32'h100) and branch_taken=1 (target 32'h200) in the same completing cycle:
  - pc=32'h100, fetch_valid=0 that edge.
  - Next fetch_pc=32'h100.
- branch_taken (target 32'h40) while imem_ready=0 for 2 more cycles, then ready:
  - FSM enters SQUASH; no fetch_valid for the squashed access.
  - pc becomes 32'h40 on the completion edge; next fetch_pc=32'h40.
- In SQUASH, a second redirect (jump_target 32'h80) before completion:
  - pend_target is overwritten; pc becomes 32'h80 on completion.
- RESET_PC=32'hFFFF_FFFC, imem_ready=1:
  - fetch_pc=32'hFFFF_FFFC with fetch_pc_plus4=0; next fetch_pc=0.
  - Separately, reset asserted while in SQUASH: pc returns to RESET_PC and imem_req=0.
